binary_to_bcd_iter: RTL



---
 rtl/binary_to_bcd_iter_pkg.sv | 17 +
 rtl/binary_to_bcd_iter_if.sv | 12 +
 rtl/binary_to_bcd_iter_add3.sv | 7 +
 rtl/binary_to_bcd_iter.sv | 75 +++++++
 4 files changed

// File: rtl/binary_to_bcd_iter_pkg.sv
// bcd_pkg: shared FSM states, BCD constants and digit-count helper for binary_to_bcd_iter
package bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  function automatic int bcd_digits_needed(input int width);
    longint unsigned v;
    int d;
    v = 1;
    d = 0;
    for (int i = 0; i < width && i < 63; i++) v = v << 1;
    while (v != 0) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/binary_to_bcd_iter_if.sv
// binary_to_bcd_iter_if: start/bitcode request in, busy/done/bcdcode/overflow/blank result out
interface binary_to_bcd_iter_if #(parameter int BIN_W = 10, parameter int DIGITS = 4);
  logic start;
  logic [BIN_W-1:0] bitcode;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcdcode;
  logic overflow;
  logic [DIGITS-1:0] blank;
  modport master(output start, bitcode, input busy, done, bcdcode, overflow, blank);
  modport slave(input start, bitcode, output busy, done, bcdcode, overflow, blank);
endinterface

// File: rtl/binary_to_bcd_iter_add3.sv
// bcd_add3: double-dabble digit adjust, d in, q = d+3 when d>=5 else d
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/binary_to_bcd_iter.sv
// binary_to_bcd_iter: one-bit-per-clock double-dabble converter, clk/rst plus bus (start,bitcode -> busy,done,bcdcode,overflow,blank)
module binary_to_bcd_iter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  binary_to_bcd_iter_if.slave bus
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;
  state_t state;
  logic [BIN_W-1:0] bin;
  logic [SW-1:0] scr, adj, scr_n, res;
  logic [CW-1:0] cnt;
  logic ovf, ovf_n, last, z;
  logic [DIGITS-1:0] blank_n;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (.d(scr[4*i+:4]), .q(adj[4*i+:4]));
  end
  always_comb begin
    scr_n = {adj[SW-2:0], bin[BIN_W-1]};
    ovf_n = ovf | adj[SW-1];
    last  = cnt == CW'(BIN_W - 1);
    res   = ovf_n ? {DIGITS{BCD_NINE}} : scr_n;
    z     = 1'b1;
    blank_n = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (res[4*i+:4] == 4'd0);
      blank_n[i] = z;
    end
    blank_n[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bin          <= '0;
      scr          <= '0;
      ovf          <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.bcdcode  <= '0;
      bus.blank    <= ~DIGITS'(1);
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          bin      <= bus.bitcode;
          scr      <= '0;
          ovf      <= 1'b0;
          cnt      <= '0;
          state    <= SHIFT;
          bus.busy <= 1'b1;
        end
      end else begin
        bin <= bin << 1;
        scr <= scr_n;
        ovf <= ovf_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          bus.bcdcode  <= res;
          bus.overflow <= ovf_n;
          bus.blank    <= blank_n;
        end
      end
    end
  end
endmodule
